lcd_bus_ctrl: RTL
=================

# lcd_bus_ctrl

Parametrised write engine for an HD44780-class character LCD, placed between game/display logic and the chip pins that carry RS, RW, enable_l and the data bus. Accepts command/data bytes over a valid/ready handshake into a small FIFO. Generates the setup, enable-pulse, hold and execution-wait timing for each byte in either 8-bit or 4-bit bus mode. Game logic no longer sequences LCD timing itself.

## Interface
Parameters:
- BUS_W, 8: pin bus width; 8 or 4 only. 4 selects nibble mode.
- DEPTH, 4: FIFO entries; power of 2, at least 2.
- T_SETUP, 2: cycles RS/bus are stable before enable_l falls; at least 1.
- T_PULSE, 10: cycles enable_l is held low; at least 1.
- T_HOLD, 2: cycles RS/bus are held after enable_l rises; at least 1.
- T_EXEC, 2000: wait cycles after a normal byte completes.
- T_CLR, 80000: wait cycles after a clear/home command.

Ports:
- clock, input, 1: sole clock.
- reset, input, 1: synchronous, active-high.
- in_valid, input, 1: byte offered.
- in_ready, output, 1: FIFO can accept a byte; equals fifo_count < DEPTH.
- in_rs, input, 1: 0 = command, 1 = data.
- in_data, input, 8: byte to write.
- busy, output, 1: FSM not in IDLE.
- fifo_count, output, $clog2(DEPTH)+1: current occupancy.
- RS, output, 1: LCD register select.
- RW, output, 1: constant 0 (write-only).
- enable_l, output, 1: LCD enable strobe, active low.
- bus, output, BUS_W: LCD data pins.

## Operation
- Push: a byte enters the FIFO on a clock where in_valid && in_ready.
- Pop: occurs on the cycle the FSM leaves IDLE with a non-empty FIFO.
- Push and pop in the same cycle: fifo_count is unchanged.
- A full FIFO drops in_ready, so push and pop never collide at DEPTH.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC (plus INIT states when configured). One down-counter is reloaded on each transition.
- IDLE → SETUP: on pop. The popped RS and bus value are registered here.
- SETUP → PULSE: after T_SETUP cycles. enable_l goes 0.
- PULSE → HOLD: after T_PULSE cycles. enable_l goes 1.
- HOLD → EXEC (8-bit mode, or after the second nibble): after T_HOLD cycles.
- HOLD → SETUP (first nibble in 4-bit mode): after T_HOLD cycles. The second nibble in[3:0] is driven; RS is unchanged.
- In 4-bit mode the first nibble driven is in[7:4].
- EXEC → IDLE: after the wait count. The wait is T_CLR if RS=0 and data is 0x01 (clear) or data[7:1]=7'b0000001 (home). Otherwise it is T_EXEC.
- In IDLE, bus and RS keep their last values and enable_l=1.
- Reset values: RS=0, RW=0, enable_l=1, bus=0, busy=0, fifo_count=0, in_ready=1, FIFO pointers 0.
- Reset mid-operation: the next edge forces reset values. This aborts any pulse (enable_l=1 immediately) and flushes the FIFO. No partial nibble is resumed.

## Timing
- Latency, empty FIFO and idle FSM:
  - Byte accepted at edge N.
  - Popped and bus/RS valid at edge N+1.
  - enable_l low at edge N+1+T_SETUP, for T_PULSE cycles.
- Single byte occupancy from pop to IDLE:
  - 8-bit mode: T_SETUP+T_PULSE+T_HOLD+wait cycles.
  - 4-bit mode: 2·(T_SETUP+T_PULSE+T_HOLD)+wait cycles.
- Back-to-back bytes: the next pop happens on the cycle EXEC exits to IDLE, with no extra idle cycle when the FIFO is non-empty.
- All outputs are registered. in_ready and fifo_count are combinational from registered state.

## Configuration
- LCD_INIT_SEQ_EN defined: after reset the controller runs a power-on sequence before serving the FIFO.
  - Wait T_CLR cycles.
  - 8-bit mode: writes 0x38, 0x0C, 0x01, 0x06 as commands, each with normal pulse timing and its exec wait (0x01 uses T_CLR).
  - 4-bit mode: first one lone nibble 0x2 followed by a T_EXEC wait, then 0x28, 0x0C, 0x01, 0x06.
  - busy=1 throughout. The FIFO accepts pushes during init.
- LCD_INIT_SEQ_EN undefined: the FSM enters IDLE straight from reset and busy=0 after reset. The user must issue the init commands.

## Test plan
- Parameters for all scenarios: T_SETUP=2, T_PULSE=3, T_HOLD=1, T_EXEC=5, T_CLR=20, DEPTH=4.
- Reset: hold reset 3 cycles, then release → RS=0, RW=0, enable_l=1, bus=0, in_ready=1, fifo_count=0. busy=0 (macro off).
- 8-bit data write: push RS=1, data=0x41 at edge N → bus=0x41 and RS=1 from N+1, enable_l low for exactly edges N+3..N+5, busy falls after 11 cycles of occupancy.
- 4-bit write (BUS_W=4): push command 0x28 → bus=0x2 pulsed, then bus=0x8 pulsed, one T_EXEC wait only after the second nibble.
- Clear timing: push command 0x01, then data 0x42 → 20-cycle wait before 0x42 is popped. A 0x02 (home) also waits 20 cycles, while 0x03 waits 20 and 0x04 waits 5.
- FIFO full: push 6 bytes while busy → in_ready=0 at fifo_count=4, two dropped, four bytes emitted in order, fifo_count returns to 0.
- Reset mid-pulse: assert reset while enable_l=0 → enable_l=1 at the next edge, FIFO empty, no further strobes. With LCD_INIT_SEQ_EN defined: 0x38, 0x0C, 0x01, 0x06 are emitted after a 20-cycle wait.

Source files
------------

// File: rtl/lcd_bus_ctrl.sv
// Write engine for an HD44780-class LCD: byte FIFO plus setup/pulse/hold/exec timing in 8- or 4-bit bus mode.
// Optional power-on init sequence enabled by defining LCD_INIT_SEQ_EN.
module lcd_bus_ctrl #(
    parameter int unsigned BUS_W   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000,
    parameter int unsigned T_CLR   = 80000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_rs,
    input  logic [7:0]               in_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     RS,
    output logic                     RW,
    output logic                     enable_l,
    output logic [BUS_W-1:0]         bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CTW   = AW + 1;
    localparam int unsigned T_M1  = (T_CLR > T_EXEC) ? T_CLR : T_EXEC;
    localparam int unsigned T_M2  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int unsigned T_M3  = (T_M2 > T_HOLD) ? T_M2 : T_HOLD;
    localparam int unsigned T_MAX = (T_M1 > T_M3) ? T_M1 : T_M3;
    localparam int unsigned CW    = $clog2(T_MAX + 1);
    localparam bit          NIBBLE = (BUS_W == 4);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC
`ifdef LCD_INIT_SEQ_EN
        , S_INIT
`endif
    } state_t;

`ifdef LCD_INIT_SEQ_EN
    localparam state_t      RST_STATE  = S_INIT;
    localparam logic        RST_BUSY   = 1'b1;
    localparam int unsigned RST_CNT    = T_CLR - 1;
    localparam int unsigned INIT_LAST  = NIBBLE ? 4 : 3;

    // {lone nibble, command byte}; 4-bit mode opens with a lone 0x2 nibble
    function automatic logic [8:0] init_item(input logic [2:0] idx);
        logic [2:0] k;
        k = NIBBLE ? idx - 3'd1 : idx;
        if (NIBBLE && idx == 3'd0) return 9'h120;
        case (k)
            3'd0:    return NIBBLE ? 9'h028 : 9'h038;
            3'd1:    return 9'h00C;
            3'd2:    return 9'h001;
            default: return 9'h006;
        endcase
    endfunction

    logic [2:0] init_idx_q, init_idx_n;
    logic       init_go;
`else
    localparam state_t      RST_STATE  = S_IDLE;
    localparam logic        RST_BUSY   = 1'b0;
    localparam int unsigned RST_CNT    = 0;
`endif

    logic [7:0]     mem_data [DEPTH];
    logic           mem_rs   [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [CTW-1:0] count_q;
    logic           push_c, pop_c;

    state_t         state_q, state_n;
    logic [CW-1:0]  cnt_q, cnt_n, exec_load;
    logic           rs_q, rs_n, en_q, en_n, busy_q, busy_n;
    logic           first_q, first_n, lone_q, lone_n;
    logic [BUS_W-1:0] bus_q, bus_n;
    logic [7:0]     data_q, data_n;
    logic           cnt_zero, fifo_go, start, st_rs, st_lone;
    logic [7:0]     st_data;

    assign in_ready   = (count_q < CTW'(DEPTH));
    assign fifo_count = count_q;
    assign push_c     = in_valid && in_ready;
    assign RS         = rs_q;
    assign RW         = 1'b0;
    assign enable_l   = en_q;
    assign bus        = bus_q;
    assign busy       = busy_q;

    // Clear (0x01) and home (0x02/0x03) commands need the long execution wait
    assign exec_load = (!rs_q && (data_q == 8'h01 || data_q[7:1] == 7'h01))
                       ? CW'(T_CLR - 1) : CW'(T_EXEC - 1);
    assign cnt_zero  = (cnt_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_c) wr_q <= wr_q + AW'(1);
            if (pop_c)  rd_q <= rd_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CTW'(1);
                2'b01:   count_q <= count_q - CTW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_c) begin
            mem_data[wr_q] <= in_data;
            mem_rs[wr_q]   <= in_rs;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_zero ? cnt_q : cnt_q - CW'(1);
        rs_n    = rs_q;
        en_n    = en_q;
        bus_n   = bus_q;
        data_n  = data_q;
        first_n = first_q;
        lone_n  = lone_q;
        pop_c   = 1'b0;
        fifo_go = 1'b0;
        start   = 1'b0;
        st_rs   = 1'b0;
        st_lone = 1'b0;
        st_data = 8'h00;
`ifdef LCD_INIT_SEQ_EN
        init_idx_n = init_idx_q;
        init_go    = 1'b0;
`endif
        case (state_q)
            S_IDLE:  fifo_go = 1'b1;
            S_SETUP: if (cnt_zero) begin
                state_n = S_PULSE;
                cnt_n   = CW'(T_PULSE - 1);
                en_n    = 1'b0;
            end
            S_PULSE: if (cnt_zero) begin
                state_n = S_HOLD;
                cnt_n   = CW'(T_HOLD - 1);
                en_n    = 1'b1;
            end
            S_HOLD: if (cnt_zero) begin
                if (NIBBLE && first_q && !lone_q) begin
                    state_n = S_SETUP;
                    cnt_n   = CW'(T_SETUP - 1);
                    bus_n   = BUS_W'(data_q[3:0]);
                    first_n = 1'b0;
                end else begin
                    state_n = S_EXEC;
                    cnt_n   = exec_load;
                end
            end
            S_EXEC: if (cnt_zero) begin
                state_n = S_IDLE;
                fifo_go = 1'b1;
`ifdef LCD_INIT_SEQ_EN
                if (init_idx_q <= 3'(INIT_LAST)) begin
                    fifo_go = 1'b0;
                    init_go = 1'b1;
                end
`endif
            end
`ifdef LCD_INIT_SEQ_EN
            S_INIT: if (cnt_zero) init_go = 1'b1;
`endif
            default: state_n = S_IDLE;
        endcase

        // Next byte launches on the same edge the FSM would otherwise return to IDLE
        if (fifo_go && count_q != '0) begin
            pop_c   = 1'b1;
            start   = 1'b1;
            st_rs   = mem_rs[rd_q];
            st_data = mem_data[rd_q];
        end
`ifdef LCD_INIT_SEQ_EN
        if (init_go) begin
            start              = 1'b1;
            {st_lone, st_data} = init_item(init_idx_q);
            init_idx_n         = init_idx_q + 3'd1;
        end
`endif
        if (start) begin
            state_n = S_SETUP;
            cnt_n   = CW'(T_SETUP - 1);
            rs_n    = st_rs;
            data_n  = st_data;
            lone_n  = st_lone;
            first_n = 1'b1;
            bus_n   = NIBBLE ? BUS_W'(st_data[7:4]) : BUS_W'(st_data);
        end
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RST_STATE;
            cnt_q   <= CW'(RST_CNT);
            rs_q    <= 1'b0;
            en_q    <= 1'b1;
            bus_q   <= '0;
            data_q  <= 8'h00;
            first_q <= 1'b0;
            lone_q  <= 1'b0;
            busy_q  <= RST_BUSY;
`ifdef LCD_INIT_SEQ_EN
            init_idx_q <= 3'd0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            rs_q    <= rs_n;
            en_q    <= en_n;
            bus_q   <= bus_n;
            data_q  <= data_n;
            first_q <= first_n;
            lone_q  <= lone_n;
            busy_q  <= busy_n;
`ifdef LCD_INIT_SEQ_EN
            init_idx_q <= init_idx_n;
`endif
        end
    end
endmodule
